// File: rtl/counter_controller_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default width.
package counter_controller_pkg;

  localparam int DEFAULT_WIDTH = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/counter_controller_count_core.sv
// WIDTH-bit counter register with synchronous clear, enable and wrap-to-zero.
// Clear dominates enable; wrap_zero selects 0 instead of count+1 when enabled.
module count_core #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             wrap_zero,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = wrap_zero ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_controller.sv
// Sequencer for the counter core: start/pause/stop/terminate against a latched
// limit in one-shot or periodic mode, with registered done and wrap pulses.
module counter_controller
  import counter_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             wrap_q, wrap_d;

  logic             at_limit;
  logic             start_ok;
  logic             active;
  logic             advancing;
  logic             core_clear;
  logic             core_enable;

  assign at_limit = (count == limit_q);
  assign active   = (state_q == ST_RUN) || (state_q == ST_HOLD);
  // stop beats start, and a running count is never restarted
  assign start_ok = start && !stop && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)                           state_d = ST_IDLE;
        else if (hold)                      state_d = ST_HOLD;
        else if (at_limit && !periodic_q)   state_d = ST_DONE;
      end
      ST_HOLD: begin
        if (stop)       state_d = ST_IDLE;
        else if (!hold) state_d = ST_RUN;
      end
      ST_DONE: state_d = start_ok ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (start_ok) begin
      limit_d    = limit;
      periodic_d = periodic;
    end
  end

  always_comb begin
    advancing   = (state_q == ST_RUN) && !stop && !hold;
    core_clear  = start_ok || (active && stop);
    // one-shot terminal cycle leaves the count parked at the limit
    core_enable = advancing && !(at_limit && !periodic_q);
    wrap_d      = advancing && at_limit && periodic_q;
  end

  count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .clear     (core_clear),
    .enable    (core_enable),
    .wrap_zero (at_limit),
    .count     (count)
  );

  assign busy = active;
  assign done = (state_q == ST_DONE);
  assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_controller.sv
// Directed bench for counter_controller: a vector table applied one edge at a
// time, followed by hand-written latency and wrap-period sequences.
module tb_counter_controller;

  localparam int W = 3;

  logic         clock;
  logic         reset;
  logic         start;
  logic         stop;
  logic         hold;
  logic         periodic;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         wrap;

  int n_checks = 0;
  int n_fail   = 0;

  counter_controller #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .periodic (periodic),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    bit         st;
    bit         sp;
    bit         hd;
    bit         pe;
    logic [W-1:0] lim;
    logic [W-1:0] exp_count;
    bit         exp_busy;
    bit         exp_done;
    bit         exp_wrap;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit rst, bit st, bit sp, bit hd, bit pe, int lim,
                              int c, bit b, bit d, bit w);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.hd = hd; v.pe = pe;
    v.lim = W'(lim);
    v.exp_count = W'(c);
    v.exp_busy = b; v.exp_done = d; v.exp_wrap = w;
    vq.push_back(v);
  endfunction

  function automatic void idle(int c, bit b, bit d, bit w);
    add(0, 0, 0, 0, 0, 0, c, b, d, w);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    reset = v.rst; start = v.st; stop = v.sp; hold = v.hd;
    periodic = v.pe; limit = v.lim;
    @(posedge clock);
    #1;
    n_checks++;
    if ({count, busy, done, wrap} !== {v.exp_count, v.exp_busy, v.exp_done, v.exp_wrap}) begin
      n_fail++;
      $display("FAIL vec%0d: got count=%0d busy=%b done=%b wrap=%b, expected count=%0d busy=%b done=%b wrap=%b",
               idx, count, busy, done, wrap, v.exp_count, v.exp_busy, v.exp_done, v.exp_wrap);
    end else begin
      $display("vec%0d ok: rst=%b start=%b stop=%b hold=%b per=%b lim=%0d -> count=%0d busy=%b done=%b wrap=%b",
               idx, v.rst, v.st, v.sp, v.hd, v.pe, v.lim, count, busy, done, wrap);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("%s ok: %0d", name, act);
    end
  endtask

  initial begin
    int first_done;
    int n_done;
    int n_wrap;

    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    periodic = 1'b0; limit = '0;

    // reset state
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // one-shot limit 5: counts 0..5, single done, count parks at 5
    add(0, 1, 0, 0, 0, 5, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) idle(k, 1, 0, 0);
    idle(5, 0, 1, 0);
    idle(5, 0, 0, 0);
    idle(5, 0, 0, 0);
    // periodic limit 2 with start/limit/mode toggling mid-run (all ignored)
    add(0, 1, 0, 0, 1, 2, 0, 1, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 1, 0, 0, 0, 7, k % 3, 1, 0, (k % 3) == 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // limit changed from 6 to 1 mid-count: still terminates at 6
    add(0, 1, 0, 0, 0, 6, 0, 1, 0, 0);
    for (int k = 1; k <= 6; k++) add(0, 0, 0, 0, 0, 1, k, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 6, 0, 1, 0);
    idle(6, 0, 0, 0);
    // stop at count 4 of limit 6
    add(0, 1, 0, 0, 0, 6, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) idle(k, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // start together with stop in IDLE
    add(0, 1, 1, 0, 0, 3, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // limit 7 with three hold cycles at count 3, then release edge
    add(0, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) idle(k, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 0, 0, 3, 1, 0, 0);
    idle(3, 1, 0, 0);
    for (int k = 4; k <= 7; k++) idle(k, 1, 0, 0);
    idle(7, 0, 1, 0);
    idle(7, 0, 0, 0);
    // limit 0 one-shot, then restart straight from DONE with limit 2
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 2, 0, 1, 0, 0);
    idle(1, 1, 0, 0);
    idle(2, 1, 0, 0);
    idle(2, 0, 1, 0);
    idle(2, 0, 0, 0);
    // limit 0 periodic: wrap every cycle, count stuck at 0
    add(0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    idle(0, 1, 0, 1);
    idle(0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // reset mid-count at 3
    add(0, 1, 0, 0, 0, 5, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) idle(k, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // full-range periodic: 0..7 then wrap
    add(0, 1, 0, 0, 1, 7, 0, 1, 0, 0);
    for (int k = 1; k <= 7; k++) idle(k, 1, 0, 0);
    idle(0, 1, 0, 1);
    idle(1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) apply(i, vq[i]);

    // done latency for limit 5, counted in edges after the start edge
    reset = 1'b0; stop = 1'b0; hold = 1'b0;
    start = 1'b1; periodic = 1'b0; limit = W'(5);
    @(posedge clock);
    #1;
    start = 1'b0; limit = '0;
    first_done = -1;
    n_done = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clock);
      #1;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = e;
      end
    end
    check("done_latency", first_done, 6);
    check("done_pulses", n_done, 1);

    // periodic limit 2 over 12 edges: wrap every 3rd edge, never done
    start = 1'b1; periodic = 1'b1; limit = W'(2);
    @(posedge clock);
    #1;
    start = 1'b0; periodic = 1'b0; limit = '0;
    n_wrap = 0;
    n_done = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clock);
      #1;
      if (wrap) n_wrap++;
      if (done) n_done++;
    end
    check("wrap_pulses", n_wrap, 4);
    check("periodic_done", n_done, 0);
    stop = 1'b1;
    @(posedge clock);
    #1;
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
